blk_959734: RTL and testbench

ECE178_NIOS_20_1_PROJECT_NIOS2_GEN2_0_CPU_DEBUG_OCIMEM_CTRL -- requirements
Module: ECE178_nios_20_1_project_nios2_gen2_0_cpu_debug_ocimem_ctrl

---
 rtl/blk_959734_pkg.sv | 26 ++
 rtl/blk_959734_if.sv | 22 ++
 rtl/blk_959734_ram.sv | 41 ++++
 rtl/blk_959734.sv | 193 +++++++++++++++++++
 tb/tb_blk_959734.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/blk_959734_pkg.sv
// Shared definitions for the debug on-chip memory controller: default sizes,
// FSM states, JTAG command kinds and the positions of the fields inside jdo.
package blk_959734_pkg;

   localparam int ADDR_W_DEF    = 8;
   localparam int JDO_W         = 38;
   localparam int JDO_ADDR_MSB  = 33;
   localparam int JDO_ADDR_LSB  = 26;
   localparam int JDO_DATA_MSB  = 35;
   localparam int JDO_DATA_LSB  = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_J_RD  = 2'd1,
      ST_J_CAP = 2'd2,
      ST_C_RD  = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      CMD_NONE = 2'd0,
      CMD_A    = 2'd1,
      CMD_NA   = 2'd2,
      CMD_B    = 2'd3
   } cmd_e;

endpackage

// File: rtl/blk_959734_if.sv
// CPU-side slave bus of the debug RAM (Avalon-style, combinational waitrequest).
interface blk_959734_if import blk_959734_pkg::*; #(
   parameter int ADDR_W = ADDR_W_DEF
);
   logic [ADDR_W-1:0] ocimem_address;
   logic              ocimem_read;
   logic              ocimem_write;
   logic [31:0]       ocimem_writedata;
   logic [3:0]        ocimem_byteenable;
   logic [31:0]       ocimem_readdata;
   logic              ocimem_waitrequest;

   modport master (
      output ocimem_address, ocimem_read, ocimem_write, ocimem_writedata, ocimem_byteenable,
      input  ocimem_readdata, ocimem_waitrequest
   );

   modport slave (
      input  ocimem_address, ocimem_read, ocimem_write, ocimem_writedata, ocimem_byteenable,
      output ocimem_readdata, ocimem_waitrequest
   );
endinterface

// File: rtl/blk_959734_ram.sv
// Single-port 2^ADDR_W x 32 debug RAM with byte-enabled writes and a one-cycle
// registered read. Only the read register is reset; contents survive reset.
module ECE178_nios_20_1_project_nios2_gen2_0_cpu_debug_ocimem_ram #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic              we_i,
   input  logic [3:0]        be_i,
   input  logic [31:0]       wdata_i,
   input  logic              re_i,
   output logic [31:0]       rdata_o
);
   logic [31:0] mem_q [2**ADDR_W];
   logic [31:0] rdata_q;

   // Byte-lane writes into the storage array.
   always_ff @(posedge clk) begin
      if (we_i) begin
         for (int i = 0; i < 4; i++) begin
            if (be_i[i]) begin
               mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
         end
      end
   end

   // Registered read port; holds its value between reads.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rdata_q <= 32'h0000_0000;
      end else if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end else begin
         rdata_q <= rdata_q;
      end
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/blk_959734.sv
// Debug OCI memory controller: arbitrates JTAG monitor commands (priority,
// one-deep pending slot) and CPU accesses onto a single-port debug RAM.
module blk_959734 import blk_959734_pkg::*; #(
   parameter int          ADDR_W       = ADDR_W_DEF,
   parameter logic [31:0] MONDREG_INIT = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [JDO_W-1:0]  jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_no_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   blk_959734_if.slave       cpu,
   output logic [31:0]       MonDReg,
   output logic [ADDR_W-1:0] MonAReg,
   output logic              monitor_ready,
   output logic              jtag_overrun
);
   state_e             state_q, state_d;
   logic [31:0]        mondreg_q, mondreg_d;
   logic [ADDR_W-1:0]  monareg_q, monareg_d;
   logic               ready_q, ready_d;
   logic               overrun_q, overrun_d;
   logic               pend_valid_q, pend_valid_d;
   cmd_e               pend_cmd_q, pend_cmd_d;
   logic [JDO_W-1:0]   pend_jdo_q, pend_jdo_d;

   cmd_e               strobe_cmd_s, acc_cmd_s;
   logic [JDO_W-1:0]   acc_jdo_s;
   logic [ADDR_W-1:0]  ram_addr_s;
   logic               ram_we_s, ram_re_s;
   logic [3:0]         ram_be_s;
   logic [31:0]        ram_wdata_s, ram_rdata_s;
   logic               cpu_done_s;
   logic               unused_s;

   // Decode the strobes; simultaneous strobes resolve a > no_action > b.
   always_comb begin
      strobe_cmd_s = CMD_NONE;
      if (take_action_ocimem_a) begin
         strobe_cmd_s = CMD_A;
      end else if (take_no_action_ocimem_a) begin
         strobe_cmd_s = CMD_NA;
      end else if (take_action_ocimem_b) begin
         strobe_cmd_s = CMD_B;
      end else begin
         strobe_cmd_s = CMD_NONE;
      end
   end

   // Next-state, RAM port mux and pending-slot bookkeeping.
   always_comb begin
      state_d      = state_q;
      mondreg_d    = mondreg_q;
      monareg_d    = monareg_q;
      ready_d      = ready_q;
      overrun_d    = overrun_q;
      pend_valid_d = pend_valid_q;
      pend_cmd_d   = pend_cmd_q;
      pend_jdo_d   = pend_jdo_q;
      acc_cmd_s    = pend_valid_q ? pend_cmd_q : strobe_cmd_s;
      acc_jdo_s    = pend_valid_q ? pend_jdo_q : jdo;
      ram_addr_s   = cpu.ocimem_address;
      ram_we_s     = 1'b0;
      ram_re_s     = 1'b0;
      ram_be_s     = cpu.ocimem_byteenable;
      ram_wdata_s  = cpu.ocimem_writedata;
      cpu_done_s   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (pend_valid_q || (strobe_cmd_s != CMD_NONE)) begin
               ready_d = 1'b0;
               // The pending slot drains first; a new strobe this cycle refills it.
               if (pend_valid_q) begin
                  pend_valid_d = (strobe_cmd_s != CMD_NONE);
                  pend_cmd_d   = strobe_cmd_s;
                  pend_jdo_d   = jdo;
               end else begin
                  pend_valid_d = 1'b0;
               end
               case (acc_cmd_s)
                  CMD_A: begin
                     monareg_d = ADDR_W'(acc_jdo_s[JDO_ADDR_MSB:JDO_ADDR_LSB]);
                     state_d   = ST_J_RD;
                  end
                  CMD_NA: begin
                     ram_addr_s = monareg_q;
                     ram_re_s   = 1'b1;
                     state_d    = ST_J_CAP;
                  end
                  CMD_B: begin
                     ram_addr_s  = monareg_q;
                     ram_we_s    = 1'b1;
                     ram_be_s    = 4'hF;
                     ram_wdata_s = acc_jdo_s[JDO_DATA_MSB:JDO_DATA_LSB];
                     mondreg_d   = acc_jdo_s[JDO_DATA_MSB:JDO_DATA_LSB];
                     monareg_d   = monareg_q + ADDR_W'(1);
                     ready_d     = 1'b1;
                  end
                  default: begin
                     state_d = ST_IDLE;
                  end
               endcase
            end else if (cpu.ocimem_write) begin
               ram_we_s   = 1'b1;
               cpu_done_s = 1'b1;
            end else if (cpu.ocimem_read) begin
               ram_re_s = 1'b1;
               state_d  = ST_C_RD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_J_RD: begin
            ram_addr_s = monareg_q;
            ram_re_s   = 1'b1;
            state_d    = ST_J_CAP;
         end
         ST_J_CAP: begin
            mondreg_d = ram_rdata_s;
            ready_d   = 1'b1;
            monareg_d = monareg_q + ADDR_W'(1);
            state_d   = ST_IDLE;
         end
         ST_C_RD: begin
            cpu_done_s = cpu.ocimem_read;
            state_d    = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Strobes arriving while busy park in the slot or are lost.
      if ((state_q != ST_IDLE) && (strobe_cmd_s != CMD_NONE)) begin
         if (pend_valid_q) begin
            overrun_d = 1'b1;
         end else begin
            pend_valid_d = 1'b1;
            pend_cmd_d   = strobe_cmd_s;
            pend_jdo_d   = jdo;
         end
      end else begin
         overrun_d = overrun_d;
      end
   end

   // State and monitor registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         mondreg_q    <= MONDREG_INIT;
         monareg_q    <= '0;
         ready_q      <= 1'b0;
         overrun_q    <= 1'b0;
         pend_valid_q <= 1'b0;
         pend_cmd_q   <= CMD_NONE;
         pend_jdo_q   <= '0;
      end else begin
         state_q      <= state_d;
         mondreg_q    <= mondreg_d;
         monareg_q    <= monareg_d;
         ready_q      <= ready_d;
         overrun_q    <= overrun_d;
         pend_valid_q <= pend_valid_d;
         pend_cmd_q   <= pend_cmd_d;
         pend_jdo_q   <= pend_jdo_d;
      end
   end

   // Writes are gated by reset so an aborted command never lands in the RAM.
   ECE178_nios_20_1_project_nios2_gen2_0_cpu_debug_ocimem_ram #(
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .reset_n (reset_n),
      .addr_i  (ram_addr_s),
      .we_i    (ram_we_s & reset_n),
      .be_i    (ram_be_s),
      .wdata_i (ram_wdata_s),
      .re_i    (ram_re_s),
      .rdata_o (ram_rdata_s)
   );

   assign cpu.ocimem_readdata    = ram_rdata_s;
   assign cpu.ocimem_waitrequest = (cpu.ocimem_read | cpu.ocimem_write) & ~cpu_done_s;
   assign MonDReg       = mondreg_q;
   assign MonAReg       = monareg_q;
   assign monitor_ready = ready_q;
   assign jtag_overrun  = overrun_q;
   assign unused_s      = ^{acc_jdo_s[JDO_W-1:JDO_DATA_MSB+1], acc_jdo_s[JDO_DATA_LSB-1:0]};
endmodule

// File: tb/tb_blk_959734.sv
// Directed bench for blk_959734: table-driven CPU accesses plus hand-written
// JTAG command, arbitration, overrun and reset sequences.
module tb_blk_959734;
   localparam logic [31:0] INIT = 32'h5A5A_1234;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [37:0] jdo;
   logic        take_a, take_na, take_b;
   logic [31:0] mondreg;
   logic [7:0]  monareg;
   logic        mon_ready, overrun;
   int          n_chk = 0;
   int          n_fail = 0;

   blk_959734_if #(.ADDR_W(8)) bus ();

   blk_959734 #(.ADDR_W(8), .MONDREG_INIT(INIT)) dut (
      .clk                     (clk),
      .reset_n                 (reset_n),
      .jdo                     (jdo),
      .take_action_ocimem_a    (take_a),
      .take_no_action_ocimem_a (take_na),
      .take_action_ocimem_b    (take_b),
      .cpu                     (bus),
      .MonDReg                 (mondreg),
      .MonAReg                 (monareg),
      .monitor_ready           (mon_ready),
      .jtag_overrun            (overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [7:0]  addr;
      logic [31:0] data;
      logic [3:0]  be;
   } vec_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [37:0] jdo_addr(input logic [7:0] a);
      return 38'(a) << 26;
   endfunction

   function automatic logic [37:0] jdo_data(input logic [31:0] d);
      return 38'(d) << 4;
   endfunction

   task automatic cpu_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
      bus.ocimem_address    = a;
      bus.ocimem_writedata  = d;
      bus.ocimem_byteenable = be;
      bus.ocimem_write      = 1'b1;
      #1;
      chk("wr_wait", 32'(bus.ocimem_waitrequest), 32'd0);
      tick();
      bus.ocimem_write = 1'b0;
   endtask

   task automatic cpu_read(input logic [7:0] a, input logic [31:0] exp, input string nm);
      bus.ocimem_address = a;
      bus.ocimem_read    = 1'b1;
      #1;
      chk({nm, "_wait1"}, 32'(bus.ocimem_waitrequest), 32'd1);
      tick();
      chk({nm, "_wait0"}, 32'(bus.ocimem_waitrequest), 32'd0);
      chk({nm, "_data"}, bus.ocimem_readdata, exp);
      bus.ocimem_read = 1'b0;
      tick();
   endtask

   task automatic jtag(input int kind, input logic [37:0] j);
      jdo     = j;
      take_a  = (kind == 0);
      take_na = (kind == 1);
      take_b  = (kind == 2);
      tick();
      take_a  = 1'b0;
      take_na = 1'b0;
      take_b  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[14];
      int   cyc;
      tbl[0]  = '{1'b1, 8'd5,   32'hDEAD_BEEF, 4'hF};
      tbl[1]  = '{1'b1, 8'd10,  32'h1122_3344, 4'hF};
      tbl[2]  = '{1'b1, 8'd10,  32'hAABB_CCDD, 4'b0101};
      tbl[3]  = '{1'b0, 8'd10,  32'h11BB_33DD, 4'h0};
      tbl[4]  = '{1'b0, 8'd5,   32'hDEAD_BEEF, 4'h0};
      tbl[5]  = '{1'b1, 8'd0,   32'hCAFE_F00D, 4'hF};
      tbl[6]  = '{1'b0, 8'd0,   32'hCAFE_F00D, 4'h0};
      tbl[7]  = '{1'b1, 8'd10,  32'h0000_0000, 4'b1000};
      tbl[8]  = '{1'b0, 8'd10,  32'h00BB_33DD, 4'h0};
      tbl[9]  = '{1'b1, 8'd6,   32'h0BAD_C0DE, 4'hF};
      tbl[10] = '{1'b1, 8'd254, 32'hFEED_FACE, 4'hF};
      tbl[11] = '{1'b1, 8'd1,   32'h0101_0101, 4'hF};
      tbl[12] = '{1'b0, 8'd254, 32'hFEED_FACE, 4'h0};
      tbl[13] = '{1'b1, 8'd255, 32'h0000_0000, 4'hF};

      reset_n = 1'b0;
      jdo = '0; take_a = 1'b0; take_na = 1'b0; take_b = 1'b0;
      bus.ocimem_address = '0; bus.ocimem_read = 1'b0; bus.ocimem_write = 1'b0;
      bus.ocimem_writedata = '0; bus.ocimem_byteenable = '0;
      tick();
      tick();
      chk("rst_mondreg", mondreg, INIT);
      chk("rst_monareg", 32'(monareg), 32'd0);
      chk("rst_ready", 32'(mon_ready), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      chk("rst_readdata", bus.ocimem_readdata, 32'd0);
      chk("rst_wait", 32'(bus.ocimem_waitrequest), 32'd0);
      reset_n = 1'b1;
      tick();

      for (int i = 0; i < 14; i++) begin
         if (tbl[i].wr) cpu_write(tbl[i].addr, tbl[i].data, tbl[i].be);
         else           cpu_read(tbl[i].addr, tbl[i].data, $sformatf("tbl%0d", i));
      end

      // take_action_a at 5: capture two cycles after acceptance
      jtag(0, jdo_addr(8'd5));
      chk("a5_areg_load", 32'(monareg), 32'd5);
      chk("a5_ready_clr", 32'(mon_ready), 32'd0);
      tick();
      tick();
      chk("a5_mondreg", mondreg, 32'hDEAD_BEEF);
      chk("a5_ready", 32'(mon_ready), 32'd1);
      chk("a5_areg_inc", 32'(monareg), 32'd6);

      // take_no_action_a reads at the current address (6)
      jtag(1, '0);
      chk("na_ready_clr", 32'(mon_ready), 32'd0);
      tick();
      chk("na_mondreg", mondreg, 32'h0BAD_C0DE);
      chk("na_areg", 32'(monareg), 32'd7);
      chk("na_ready", 32'(mon_ready), 32'd1);

      // position at 255 then take_action_b with wrap
      jtag(0, jdo_addr(8'd254));
      tick();
      tick();
      chk("a254_mondreg", mondreg, 32'hFEED_FACE);
      chk("a254_areg", 32'(monareg), 32'd255);
      jtag(2, jdo_data(32'h1234_5678));
      chk("b_mondreg", mondreg, 32'h1234_5678);
      chk("b_areg_wrap", 32'(monareg), 32'd0);
      chk("b_ready", 32'(mon_ready), 32'd1);
      cpu_read(8'd255, 32'h1234_5678, "rd255");

      // read-path increment wraps too
      jtag(0, jdo_addr(8'd255));
      tick();
      tick();
      chk("a255_mondreg", mondreg, 32'h1234_5678);
      chk("a255_areg_wrap", 32'(monareg), 32'd0);

      // JTAG strobe and CPU read in the same cycle
      bus.ocimem_address = 8'd5;
      bus.ocimem_read    = 1'b1;
      take_a = 1'b1;
      jdo    = jdo_addr(8'd10);
      #1;
      chk("arb_wait_hi", 32'(bus.ocimem_waitrequest), 32'd1);
      tick();
      take_a = 1'b0;
      cyc = 1;
      while (bus.ocimem_waitrequest && cyc < 10) begin
         tick();
         cyc++;
      end
      chk("arb_cycles", 32'(cyc), 32'd4);
      chk("arb_readdata", bus.ocimem_readdata, 32'hDEAD_BEEF);
      chk("arb_mondreg", mondreg, 32'h00BB_33DD);
      chk("arb_areg", 32'(monareg), 32'd11);
      bus.ocimem_read = 1'b0;
      tick();

      // three back-to-back strobes: a, no_action (pending), no_action (dropped)
      jdo = jdo_addr(8'd0);
      take_a = 1'b1;
      tick();
      take_a = 1'b0;
      take_na = 1'b1;
      tick();
      tick();
      take_na = 1'b0;
      chk("ovr_first_data", mondreg, 32'hCAFE_F00D);
      chk("ovr_flag", 32'(overrun), 32'd1);
      tick();
      chk("ovr_second_busy", 32'(mon_ready), 32'd0);
      tick();
      chk("ovr_second_data", mondreg, 32'h0101_0101);
      chk("ovr_second_areg", 32'(monareg), 32'd2);
      tick();
      tick();
      tick();
      chk("ovr_third_dropped", 32'(monareg), 32'd2);
      chk("ovr_sticky", 32'(overrun), 32'd1);

      // reset while in J_RD
      jtag(0, jdo_addr(8'd5));
      reset_n = 1'b0;
      tick();
      chk("rjrd_mondreg", mondreg, INIT);
      chk("rjrd_areg", 32'(monareg), 32'd0);
      chk("rjrd_ready", 32'(mon_ready), 32'd0);
      chk("rjrd_overrun", 32'(overrun), 32'd0);
      chk("rjrd_readdata", bus.ocimem_readdata, 32'd0);
      reset_n = 1'b1;
      tick();
      tick();
      chk("rjrd_idle_areg", 32'(monareg), 32'd0);
      chk("rjrd_idle_ready", 32'(mon_ready), 32'd0);
      cpu_read(8'd5, 32'hDEAD_BEEF, "rjrd_ram");

      // reset coinciding with take_action_b: no write, no increment
      reset_n = 1'b0;
      jtag(2, jdo_data(32'h7777_7777));
      reset_n = 1'b1;
      tick();
      chk("rb_mondreg", mondreg, INIT);
      chk("rb_areg", 32'(monareg), 32'd0);
      cpu_read(8'd0, 32'hCAFE_F00D, "rb_ram");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
